// File: rtl/exec_cluster_pkg.sv
// ============================================================================
//  Module      : exec_cluster_pkg
//  Description : Shared operation and state encodings for the execution cluster.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exec_cluster_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } ALU_OP_t;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } MD_OP_t;

    // Multiplies resolve at accept, so ST_MUL is never occupied for a full cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } MD_STATE_t;

    localparam int ALU_OP_W = 4;

    function automatic logic md_is_div(input MD_OP_t op);
        return op[2];
    endfunction

    function automatic logic md_is_rem(input MD_OP_t op);
        return op[2] & op[1];
    endfunction

    function automatic logic md_is_signed_div(input MD_OP_t op);
        return (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/exec_divider.sv
// ============================================================================
//  Module      : exec_divider
//  Description : Iterative restoring divider, one quotient bit per clock,
//                signed/unsigned, with kill. done is high during the final
//                iteration cycle, while result carries the sign-fixed answer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kill,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic                  is_rem,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int              c_cnt_w    = $clog2(DATA_WIDTH);
    localparam [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(DATA_WIDTH - 1);

    logic                  r_active;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_div;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_is_rem;

    logic                  w_neg_a;
    logic                  w_neg_b;
    logic [DATA_WIDTH-1:0] w_mag_a;
    logic [DATA_WIDTH-1:0] w_mag_b;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_quo_nxt;
    logic [DATA_WIDTH-1:0] w_rem_nxt;

    assign w_neg_a = is_signed & dividend[DATA_WIDTH-1];
    assign w_neg_b = is_signed & divisor[DATA_WIDTH-1];
    assign w_mag_a = w_neg_a ? -dividend : dividend;
    assign w_mag_b = w_neg_b ? -divisor  : divisor;

    // Partial remainder stays below the divisor, so W+1 bits hold the shifted value.
    always_comb begin
        w_shift   = {r_rem, r_quo[DATA_WIDTH-1]};
        w_diff    = w_shift - {1'b0, r_div};
        w_ge      = ~w_diff[DATA_WIDTH];
        w_quo_nxt = {r_quo[DATA_WIDTH-2:0], w_ge};
        w_rem_nxt = w_ge ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
    end

    assign done   = r_active & (r_cnt == c_cnt_last);
    assign result = r_is_rem ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                             : (r_neg_q ? -w_quo_nxt : w_quo_nxt);

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_mag_a;
            r_div    <= w_mag_b;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_is_rem <= is_rem;
        end else if (r_active) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/exec_cluster.sv
// ============================================================================
//  Module      : exec_cluster
//  Description : Execution stage with NUM_ALU single-cycle ALU lanes and one
//                RV32M multiply/divide lane, each with valid/ready writeback.
//                Optional EXEC_DIV_EARLY_OUT_EN: divides with |a|<|b| finish
//                at accept.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_cluster
    import exec_cluster_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 5,
    parameter int PHY_WIDTH  = 6,
    parameter int NUM_ALU    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [NUM_ALU-1:0]              alu_issue_valid,
    input  logic [NUM_ALU*ALU_OP_W-1:0]     alu_issue_op,
    input  logic [NUM_ALU*DATA_WIDTH-1:0]   alu_issue_a,
    input  logic [NUM_ALU*DATA_WIDTH-1:0]   alu_issue_b,
    input  logic [NUM_ALU*ROB_WIDTH-1:0]    alu_issue_rob_id,
    input  logic [NUM_ALU*PHY_WIDTH-1:0]    alu_issue_rd_phy,
    output logic [NUM_ALU-1:0]              alu_busy,
    output logic [NUM_ALU-1:0]              alu_wb_valid,
    input  logic [NUM_ALU-1:0]              alu_wb_ready,
    output logic [NUM_ALU*DATA_WIDTH-1:0]   alu_wb_result,
    output logic [NUM_ALU*ROB_WIDTH-1:0]    alu_wb_rob_id,
    output logic [NUM_ALU*PHY_WIDTH-1:0]    alu_wb_rd_phy,
    input  logic                            md_issue_valid,
    input  logic [2:0]                      md_issue_funct3,
    input  logic [DATA_WIDTH-1:0]           md_issue_a,
    input  logic [DATA_WIDTH-1:0]           md_issue_b,
    input  logic [ROB_WIDTH-1:0]            md_issue_rob_id,
    input  logic [PHY_WIDTH-1:0]            md_issue_rd_phy,
    output logic                            md_busy,
    output logic                            md_wb_valid,
    input  logic                            md_wb_ready,
    output logic [DATA_WIDTH-1:0]           md_wb_result,
    output logic [ROB_WIDTH-1:0]            md_wb_rob_id,
    output logic [PHY_WIDTH-1:0]            md_wb_rd_phy
);

    localparam int              c_sh_w = $clog2(DATA_WIDTH);
    localparam [DATA_WIDTH-1:0] c_min  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // ALU lanes
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_ALU; i++) begin : g_alu_lane
        logic                  r_valid;
        logic [DATA_WIDTH-1:0] r_result;
        logic [ROB_WIDTH-1:0]  r_rob;
        logic [PHY_WIDTH-1:0]  r_rd;

        ALU_OP_t               w_op;
        logic [DATA_WIDTH-1:0] w_a;
        logic [DATA_WIDTH-1:0] w_b;
        logic [c_sh_w-1:0]     w_shamt;
        logic [DATA_WIDTH-1:0] w_res;
        logic                  w_busy;
        logic                  w_accept;

        assign w_op     = ALU_OP_t'(alu_issue_op[i*ALU_OP_W +: ALU_OP_W]);
        assign w_a      = alu_issue_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_b      = alu_issue_b[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_shamt  = w_b[c_sh_w-1:0];
        assign w_busy   = r_valid & ~alu_wb_ready[i];
        assign w_accept = alu_issue_valid[i] & ~w_busy & ~flush;

        always_comb begin
            w_res = '0;
            case (w_op)
                ALU_ADD:    w_res = w_a + w_b;
                ALU_SUB:    w_res = w_a - w_b;
                ALU_SLL:    w_res = w_a << w_shamt;
                ALU_SLT:    w_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
                ALU_SLTU:   w_res = {{(DATA_WIDTH-1){1'b0}}, (w_a < w_b)};
                ALU_XOR:    w_res = w_a ^ w_b;
                ALU_SRL:    w_res = w_a >> w_shamt;
                ALU_SRA:    w_res = DATA_WIDTH'($signed(w_a) >>> w_shamt);
                ALU_OR:     w_res = w_a | w_b;
                ALU_AND:    w_res = w_a & w_b;
                ALU_PASS_B: w_res = w_b;
                default:    w_res = '0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                r_valid  <= 1'b0;
                r_result <= '0;
                r_rob    <= '0;
                r_rd     <= '0;
            end else if (w_accept) begin
                r_valid  <= 1'b1;
                r_result <= w_res;
                r_rob    <= alu_issue_rob_id[i*ROB_WIDTH +: ROB_WIDTH];
                r_rd     <= alu_issue_rd_phy[i*PHY_WIDTH +: PHY_WIDTH];
            end else if (alu_wb_ready[i]) begin
                r_valid  <= 1'b0;
            end
        end

        assign alu_busy[i]                                = w_busy;
        assign alu_wb_valid[i]                            = r_valid;
        assign alu_wb_result[i*DATA_WIDTH +: DATA_WIDTH]  = r_result;
        assign alu_wb_rob_id[i*ROB_WIDTH +: ROB_WIDTH]    = r_rob;
        assign alu_wb_rd_phy[i*PHY_WIDTH +: PHY_WIDTH]    = r_rd;
    end

    // ------------------------------------------------------------------
    // Multiply / divide lane
    // ------------------------------------------------------------------
    MD_STATE_t             r_state;
    logic                  r_md_valid;
    logic [DATA_WIDTH-1:0] r_md_result;
    logic [ROB_WIDTH-1:0]  r_md_rob;
    logic [PHY_WIDTH-1:0]  r_md_rd;

    MD_OP_t                w_md_op;
    logic                  w_md_accept;
    logic                  w_is_div;
    logic                  w_is_rem;
    logic                  w_div_signed;
    logic                  w_a_signed;
    logic                  w_b_signed;
    logic signed [DATA_WIDTH:0]     w_mul_a;
    logic signed [DATA_WIDTH:0]     w_mul_b;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0] w_mul_res;
    logic                  w_div_zero;
    logic                  w_div_ovf;
    logic                  w_div_early;
    logic                  w_div_fast;
    logic [DATA_WIDTH-1:0] w_fast_res;
    logic                  w_div_start;
    logic                  w_div_done;
    logic [DATA_WIDTH-1:0] w_div_result;

    assign w_md_op      = MD_OP_t'(md_issue_funct3);
    assign w_md_accept  = md_issue_valid & (r_state == ST_IDLE) & ~flush;
    assign w_is_div     = md_is_div(w_md_op);
    assign w_is_rem     = md_is_rem(w_md_op);
    assign w_div_signed = md_is_signed_div(w_md_op);

    // One extra bit lets a single signed multiplier cover all four flavours.
    assign w_a_signed = (w_md_op == MD_MULH) || (w_md_op == MD_MULHSU);
    assign w_b_signed = (w_md_op == MD_MULH);
    assign w_mul_a    = {w_a_signed & md_issue_a[DATA_WIDTH-1], md_issue_a};
    assign w_mul_b    = {w_b_signed & md_issue_b[DATA_WIDTH-1], md_issue_b};
    assign w_prod     = (2*DATA_WIDTH)'(w_mul_a * w_mul_b);
    assign w_mul_res  = (w_md_op == MD_MUL) ? w_prod[DATA_WIDTH-1:0]
                                            : w_prod[2*DATA_WIDTH-1:DATA_WIDTH];

    assign w_div_zero = (md_issue_b == '0);
    assign w_div_ovf  = w_div_signed & (md_issue_a == c_min) & (md_issue_b == '1);

`ifdef EXEC_DIV_EARLY_OUT_EN
    logic [DATA_WIDTH-1:0] w_mag_a;
    logic [DATA_WIDTH-1:0] w_mag_b;
    assign w_mag_a     = (w_div_signed & md_issue_a[DATA_WIDTH-1]) ? -md_issue_a : md_issue_a;
    assign w_mag_b     = (w_div_signed & md_issue_b[DATA_WIDTH-1]) ? -md_issue_b : md_issue_b;
    assign w_div_early = ~w_div_zero & (w_mag_a < w_mag_b);
`else
    assign w_div_early = 1'b0;
`endif

    assign w_div_fast = w_div_zero | w_div_ovf | w_div_early;

    always_comb begin
        w_fast_res = '0;
        if (w_div_zero) begin
            w_fast_res = w_is_rem ? md_issue_a : '1;
        end else if (w_div_ovf) begin
            w_fast_res = w_is_rem ? '0 : c_min;
        end else begin
            w_fast_res = w_is_rem ? md_issue_a : '0;
        end
    end

    assign w_div_start = w_md_accept & w_is_div & ~w_div_fast;

    exec_divider #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .kill      (flush),
        .start     (w_div_start),
        .is_signed (w_div_signed),
        .is_rem    (w_is_rem),
        .dividend  (md_issue_a),
        .divisor   (md_issue_b),
        .done      (w_div_done),
        .result    (w_div_result)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state     <= ST_IDLE;
            r_md_valid  <= 1'b0;
            r_md_result <= '0;
            r_md_rob    <= '0;
            r_md_rd     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_md_accept) begin
                        r_md_rob <= md_issue_rob_id;
                        r_md_rd  <= md_issue_rd_phy;
                        if (!w_is_div) begin
                            r_md_result <= w_mul_res;
                            r_md_valid  <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_div_fast) begin
                            r_md_result <= w_fast_res;
                            r_md_valid  <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state     <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_md_result <= w_div_result;
                        r_md_valid  <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (md_wb_ready) begin
                        r_md_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_md_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign md_busy      = (r_state != ST_IDLE);
    assign md_wb_valid  = r_md_valid;
    assign md_wb_result = r_md_result;
    assign md_wb_rob_id = r_md_rob;
    assign md_wb_rd_phy = r_md_rd;

endmodule

`default_nettype wire

// File: tb/tb_exec_cluster.sv
// ============================================================================
//  Module      : tb_exec_cluster
//  Description : Self-checking bench for exec_cluster, directed and random
//                stimulus against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_exec_cluster;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int PW = 6;
    localparam int NA = 2;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [NA-1:0]   alu_issue_valid;
    logic [NA*4-1:0] alu_issue_op;
    logic [NA*DW-1:0] alu_issue_a;
    logic [NA*DW-1:0] alu_issue_b;
    logic [NA*RW-1:0] alu_issue_rob_id;
    logic [NA*PW-1:0] alu_issue_rd_phy;
    logic [NA-1:0]   alu_busy;
    logic [NA-1:0]   alu_wb_valid;
    logic [NA-1:0]   alu_wb_ready;
    logic [NA*DW-1:0] alu_wb_result;
    logic [NA*RW-1:0] alu_wb_rob_id;
    logic [NA*PW-1:0] alu_wb_rd_phy;
    logic            md_issue_valid;
    logic [2:0]      md_issue_funct3;
    logic [DW-1:0]   md_issue_a;
    logic [DW-1:0]   md_issue_b;
    logic [RW-1:0]   md_issue_rob_id;
    logic [PW-1:0]   md_issue_rd_phy;
    logic            md_busy;
    logic            md_wb_valid;
    logic            md_wb_ready;
    logic [DW-1:0]   md_wb_result;
    logic [RW-1:0]   md_wb_rob_id;
    logic [PW-1:0]   md_wb_rd_phy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exec_cluster #(
        .DATA_WIDTH (DW),
        .ROB_WIDTH  (RW),
        .PHY_WIDTH  (PW),
        .NUM_ALU    (NA)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .alu_issue_valid  (alu_issue_valid),
        .alu_issue_op     (alu_issue_op),
        .alu_issue_a      (alu_issue_a),
        .alu_issue_b      (alu_issue_b),
        .alu_issue_rob_id (alu_issue_rob_id),
        .alu_issue_rd_phy (alu_issue_rd_phy),
        .alu_busy         (alu_busy),
        .alu_wb_valid     (alu_wb_valid),
        .alu_wb_ready     (alu_wb_ready),
        .alu_wb_result    (alu_wb_result),
        .alu_wb_rob_id    (alu_wb_rob_id),
        .alu_wb_rd_phy    (alu_wb_rd_phy),
        .md_issue_valid   (md_issue_valid),
        .md_issue_funct3  (md_issue_funct3),
        .md_issue_a       (md_issue_a),
        .md_issue_b       (md_issue_b),
        .md_issue_rob_id  (md_issue_rob_id),
        .md_issue_rd_phy  (md_issue_rd_phy),
        .md_busy          (md_busy),
        .md_wb_valid      (md_wb_valid),
        .md_wb_ready      (md_wb_ready),
        .md_wb_result     (md_wb_result),
        .md_wb_rob_id     (md_wb_rob_id),
        .md_wb_rd_phy     (md_wb_rd_phy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ALU reference: plain arithmetic on the architectural meaning of each op.
    function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int sh;
        sa = a;
        sb = b;
        sh = int'(b & 32'd31);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return 32'(sa >>> sh);
            8:  return a | b;
            9:  return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] md_ref(input int f, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (f)
            0: begin p = ua * ub; return p[31:0]; end
            1: begin p = sa * sb; return p[63:32]; end
            2: begin p = sa * ub; return p[63:32]; end
            3: begin p = ua * ub; return p[63:32]; end
            4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return 32'(sa / sb);
            end
            5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    // Cycle (issue = 0) in which the mul/div result should appear.
    function automatic int md_lat(input int f, input logic [31:0] a, input logic [31:0] b);
        longint ma;
        longint mb;
        logic   sgn;
        if (f < 4) return 1;
        if (b == 0) return 1;
        sgn = (f == 4) || (f == 6);
        if (sgn && a == MINV && b == 32'hFFFF_FFFF) return 1;
        ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef EXEC_DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return DW + 1;
    endfunction

    task automatic alu_set(input int lane, input logic v, input int op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rob, input logic [5:0] rd);
        alu_issue_valid[lane]          = v;
        alu_issue_op[lane*4 +: 4]      = 4'(op);
        alu_issue_a[lane*DW +: DW]     = a;
        alu_issue_b[lane*DW +: DW]     = b;
        alu_issue_rob_id[lane*RW +: RW] = rob;
        alu_issue_rd_phy[lane*PW +: PW] = rd;
    endtask

    task automatic md_run(input string tag, input int f, input logic [31:0] a, input logic [31:0] b);
        int         cyc;
        logic       busy_ok;
        logic [4:0] rob;
        logic [5:0] rd;
        rob = 5'($urandom);
        rd  = 6'($urandom);
        md_issue_valid  = 1'b1;
        md_issue_funct3 = 3'(f);
        md_issue_a      = a;
        md_issue_b      = b;
        md_issue_rob_id = rob;
        md_issue_rd_phy = rd;
        md_wb_ready     = 1'b1;
        tick();
        md_issue_valid = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!md_wb_valid && cyc < 100) begin
            if (!md_busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(md_lat(f, a, b)));
        check({tag, "_res"}, 64'(md_wb_result), 64'(md_ref(f, a, b)));
        check({tag, "_tag"}, 64'({md_wb_rob_id, md_wb_rd_phy}), 64'({rob, rd}));
        check({tag, "_busy"}, 64'({busy_ok, md_busy}), 64'd3);
        tick();
        check({tag, "_idle"}, 64'({md_busy, md_wb_valid}), 64'd0);
    endtask

    logic [NA-1:0] m_v;
    logic [31:0]   m_res [NA];
    logic [10:0]   m_tag [NA];

    initial begin
        logic seen;
        rst = 1'b1;
        flush = 1'b0;
        alu_issue_valid = '0;
        alu_issue_op = '0;
        alu_issue_a = '0;
        alu_issue_b = '0;
        alu_issue_rob_id = '0;
        alu_issue_rd_phy = '0;
        alu_wb_ready = '1;
        md_issue_valid = 1'b0;
        md_issue_funct3 = '0;
        md_issue_a = '0;
        md_issue_b = '0;
        md_issue_rob_id = '0;
        md_issue_rd_phy = '0;
        md_wb_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_valid", 64'({alu_wb_valid, md_wb_valid}), 64'd0);
        check("rst_busy", 64'({alu_busy, md_busy}), 64'd0);
        check("rst_data", 64'(alu_wb_result | 64'(md_wb_result)), 64'd0);

        // Lane 0 ADD, latency 1
        alu_set(0, 1'b1, 0, 32'd5, 32'd7, 5'd3, 6'd10);
        tick();
        alu_set(0, 1'b0, 0, 0, 0, 0, 0);
        check("add_valid", 64'(alu_wb_valid[0]), 64'd1);
        check("add_res", 64'(alu_wb_result[31:0]), 64'd12);
        check("add_tag", 64'({alu_wb_rob_id[4:0], alu_wb_rd_phy[5:0]}), 64'({5'd3, 6'd10}));

        // Lane 1 SRA under back-pressure
        alu_wb_ready = 2'b01;
        alu_set(1, 1'b1, 7, 32'hF000_0000, 32'd4, 5'd7, 6'd20);
        tick();
        check("sra_res", 64'(alu_wb_result[63:32]), 64'hFF00_0000);
        check("sra_busy", 64'(alu_busy), 64'b10);
        alu_set(1, 1'b1, 0, 32'd1, 32'd1, 5'd8, 6'd21);
        tick();
        check("hold_res", 64'(alu_wb_result[63:32]), 64'hFF00_0000);
        check("hold_rob", 64'(alu_wb_rob_id[9:5]), 64'd7);
        alu_issue_valid[1] = 1'b0;
        alu_wb_ready = 2'b11;
        #1;
        check("ready_busy", 64'(alu_busy), 64'd0);
        tick();
        check("retired", 64'(alu_wb_valid), 64'd0);
        alu_issue_valid[1] = 1'b1;
        tick();
        alu_issue_valid[1] = 1'b0;
        check("next_res", 64'({alu_wb_valid[1], alu_wb_result[63:32]}), 64'({1'b1, 32'd2}));
        check("next_rob", 64'(alu_wb_rob_id[9:5]), 64'd8);
        tick();

        // Multiply / divide directed cases
        md_run("mulh",   1, 32'h8000_0000, 32'h8000_0000);
        md_run("mulhu",  3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        md_run("mulhsu", 2, 32'hFFFF_FFFE, 32'h0000_0003);
        md_run("mul",    0, 32'h1234_5678, 32'h9ABC_DEF0);
        md_run("div",    4, 32'hFFFF_FFF9, 32'd2);
        md_run("rem",    6, 32'hFFFF_FFF9, 32'd2);
        md_run("div0",   4, 32'd5, 32'd0);
        md_run("remu0",  7, 32'd5, 32'd0);
        md_run("divovf", 4, MINV, 32'hFFFF_FFFF);
        md_run("removf", 6, MINV, 32'hFFFF_FFFF);
        md_run("divu_sm", 5, 32'd3, 32'd10);
        md_run("rem_sm", 6, 32'hFFFF_FFFD, 32'd10);

        // Flush mid-divide with pending ALU results
        alu_wb_ready = 2'b00;
        alu_set(0, 1'b1, 0, 32'd1, 32'd2, 5'd1, 6'd1);
        alu_set(1, 1'b1, 1, 32'd9, 32'd2, 5'd2, 6'd2);
        md_issue_valid = 1'b1;
        md_issue_funct3 = 3'd4;
        md_issue_a = 32'd1000;
        md_issue_b = 32'd7;
        tick();
        alu_issue_valid = '0;
        md_issue_valid = 1'b0;
        repeat (9) tick();
        check("pre_flush", 64'({alu_wb_valid, md_busy}), 64'b111);
        flush = 1'b1;
        alu_set(0, 1'b1, 0, 32'd4, 32'd4, 5'd4, 6'd4);
        tick();
        flush = 1'b0;
        alu_issue_valid = '0;
        check("flush_state", 64'({alu_wb_valid, md_wb_valid, md_busy}), 64'd0);
        md_issue_valid = 1'b1;
        md_issue_funct3 = 3'd0;
        md_issue_a = 32'd6;
        md_issue_b = 32'd7;
        md_wb_ready = 1'b1;
        alu_wb_ready = 2'b11;
        tick();
        md_issue_valid = 1'b0;
        check("post_mul", 64'({md_wb_valid, md_wb_result}), 64'({1'b1, 32'd42}));
        seen = 1'b0;
        tick();
        for (int k = 0; k < 40; k++) begin
            if (md_wb_valid || alu_wb_valid != 0) seen = 1'b1;
            tick();
        end
        check("no_ghost", 64'(seen), 64'd0);

        // Random ALU traffic with random back-pressure
        m_v = '0;
        for (int l = 0; l < NA; l++) begin
            m_res[l] = '0;
            m_tag[l] = '0;
        end
        for (int it = 0; it < 80; it++) begin
            int          op_r [NA];
            logic [31:0] a_r [NA];
            logic [31:0] b_r [NA];
            logic [10:0] t_r [NA];
            for (int l = 0; l < NA; l++) begin
                op_r[l] = int'($urandom_range(0, 15));
                a_r[l]  = $urandom;
                b_r[l]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                t_r[l]  = 11'($urandom);
                alu_set(l, 1'($urandom_range(0, 1)), op_r[l], a_r[l], b_r[l], t_r[l][10:6], t_r[l][5:0]);
                alu_wb_ready[l] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int l = 0; l < NA; l++) begin
                logic exp_busy;
                exp_busy = m_v[l] & ~alu_wb_ready[l];
                check("rnd_busy", 64'(alu_busy[l]), 64'(exp_busy));
                if (alu_issue_valid[l] && !exp_busy) begin
                    m_v[l]   = 1'b1;
                    m_res[l] = alu_ref(op_r[l], a_r[l], b_r[l]);
                    m_tag[l] = t_r[l];
                end else if (alu_wb_ready[l]) begin
                    m_v[l] = 1'b0;
                end
            end
            tick();
            for (int l = 0; l < NA; l++) begin
                check("rnd_valid", 64'(alu_wb_valid[l]), 64'(m_v[l]));
                if (m_v[l]) begin
                    check("rnd_res", 64'(alu_wb_result[l*DW +: DW]), 64'(m_res[l]));
                    check("rnd_tag", 64'({alu_wb_rob_id[l*RW +: RW], alu_wb_rd_phy[l*PW +: PW]}),
                          64'(m_tag[l]));
                end
            end
        end
        alu_issue_valid = '0;
        alu_wb_ready = '1;
        tick();

        // Random multiply / divide
        for (int it = 0; it < 24; it++) begin
            int          f;
            logic [31:0] a;
            logic [31:0] b;
            f = int'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = MINV; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 20));
                default: ;
            endcase
            md_run("rnd_md", f, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
